vec_issue_ctrl: RTL and testbench
=================================

VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

Interface
- REQ-001: Parameters SHALL be: VLEN, default 512, vector register length in bits; LANE_W, default 128, datapath bits issued per beat.
- REQ-002: clk  in  1  sole clock, rising edge.
- REQ-003: n_rst  in  1  asynchronous, active-low reset.
- REQ-004: inst_valid  in  1 / inst_ready  out  1  decoded-instruction handshake; transfer when both high.
- REQ-005: is_config  in  1  instruction is vsetvl/vsetvli/vsetivli.
- REQ-006: vec_op_valid  in  1  decoder flag: func6 legal for func3.
- REQ-007: vec_func6  in  6;  vd_addr, vs1_addr, vs2_addr  in  5 each  operation fields.
- REQ-008: avl  in  XLEN  requested length (scalar1); vtype_in  in  XLEN  requested vtype (scalar2).
- REQ-009: exe_valid  out  1 / exe_ready  in  1  beat handshake to execution unit.
- REQ-010: exe_func6  out  6;  exe_vd, exe_vs1, exe_vs2  out  5;  exe_beat  out  6;  exe_last  out  1.
- REQ-011: vl_o  out  XLEN;  vtype_o  out  XLEN  architectural vl/vtype.
- REQ-012: done  out  1  one-cycle completion pulse;  busy  out  1  state != IDLE;  illegal_inst  out  1  one-cycle pulse.

Function
- REQ-013: FSM states SHALL be IDLE, CONFIG, EXEC, DONE; inst_ready = 1 only in IDLE.
- REQ-014: IDLE + transfer: is_config -> CONFIG; else vec_op_valid and vl_o != 0 -> EXEC; else -> DONE.
- REQ-015: Fields (func6, addrs, avl, vtype_in) SHALL be captured at transfer; later input changes ignored.
- REQ-016: CONFIG SHALL last one cycle, write vl_o/vtype_o at its end, then go to DONE.
- REQ-017: Legal vtype: vsew (bits 5:3) in {000,001,010}, vlmul (bits 2:0) in {000,001,010,011}; anything else, or nonzero bits XLEN-2:8, is illegal.
- REQ-018: Legal: VLMAX = (VLEN << vlmul) >> (3 + vsew); vl_o = min(avl, VLMAX); vtype_o = vtype_in with bit XLEN-1 cleared.
- REQ-019: Illegal: vtype_o = 1 << (XLEN-1) (vill), vl_o = 0.
- REQ-020: EXEC: beat count N = ceil(vl_o * SEW / LANE_W), SEW = 8 << vsew; exe_beat counts 0..N-1.
- REQ-021: In EXEC, exe_valid = 1; exe_beat advances only on exe_valid & exe_ready; exe_last = (exe_beat == N-1).
- REQ-022: Outputs SHALL hold stable while exe_valid & !exe_ready.
- REQ-023: Handshake on the last beat -> DONE; exe_valid low in DONE.
- REQ-024: DONE SHALL last one cycle with done = 1, then go to IDLE; minimum config latency 2 cycles after transfer.
- REQ-025: vill set, or vl_o == 0, SHALL send an arithmetic op to DONE with no beats.

Reset
- REQ-026: Reset SHALL force IDLE, vl_o = 0, vtype_o = 1 << (XLEN-1), beat counter 0.
- REQ-027: Reset SHALL force exe_valid, done, busy, illegal_inst to 0 and inst_ready to 1; asserting mid-EXEC aborts with no further beats.

Configuration
- REQ-028: Macro VEC_ILLEGAL_TRAP_EN defined: a non-config op with vec_op_valid = 0 pulses illegal_inst with the DONE cycle and issues no beats.
- REQ-029: Macro not defined: illegal_inst is tied 0; such ops complete silently through DONE.

Structure
- REQ-030: State enum, SEW/LMUL encodings and the vill bit index SHALL reside in the shared vector package with existing vector defs.
- REQ-031: VLMAX/vl and beat-count arithmetic SHALL be a combinational sub-module vec_vl_calc.

Verification
- REQ-032: Reset -> vl_o = 0, vtype_o = 0x8000_0000, inst_ready = 1, exe_valid = 0.
- REQ-033: Config avl = 100, vtype_in = 0x10 (SEW32, LMUL1) -> vl_o = 16, vtype_o = 0x10, done 2 cycles after transfer.
- REQ-034: Then op func6 0x00, vd = 4 -> 4 beats (exe_beat 0..3), exe_last on beat 3; exe_ready low 2 cycles at beat 1 holds beat 1.
- REQ-035: Config vtype_in = 0x18 (SEW64) -> vtype_o = 0x8000_0000, vl_o = 0; following op -> done, no exe_valid.
- REQ-036: Legal vl, vec_op_valid = 0 -> illegal_inst with done if macro set, done only if not; no beats.
- REQ-037: Reset asserted at exe_beat = 2 -> exe_valid low immediately, IDLE, vl_o = 0 after release.

Source files
------------

// File: rtl/vec_issue_ctrl_pkg.sv
// ============================================================================
// Module   : vec_issue_ctrl_pkg
// Purpose  : Shared vector definitions for the vector issue controller:
//            scalar width, vill bit, issue FSM states, SEW/LMUL encodings
//            and a vtype field legality helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vec_issue_ctrl_pkg;

    localparam int XLEN = 32;

    // vtype.vill lives in the scalar MSB
    localparam int              C_VILL_BIT   = XLEN - 1;
    localparam logic [XLEN-1:0] C_VTYPE_VILL = XLEN'(1) << C_VILL_BIT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } issue_state_e;

    // Supported element widths (vtype[5:3])
    typedef enum logic [2:0] {
        VSEW_8  = 3'b000,
        VSEW_16 = 3'b001,
        VSEW_32 = 3'b010
    } vsew_e;

    // Supported integer register grouping (vtype[2:0]); fractional LMUL unsupported
    typedef enum logic [2:0] {
        VLMUL_1 = 3'b000,
        VLMUL_2 = 3'b001,
        VLMUL_4 = 3'b010,
        VLMUL_8 = 3'b011
    } vlmul_e;

    function automatic logic vtype_fields_legal(input logic [2:0] vsew,
                                                input logic [2:0] vlmul);
        return (vsew <= VSEW_32) && (vlmul <= VLMUL_8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_vl_calc.sv
// ============================================================================
// Module   : vec_vl_calc
// Purpose  : Combinational vector-length arithmetic.
//            - Config path: vtype legality, VLMAX and new vl = min(avl, VLMAX).
//            - Exec path  : beat count ceil(vl * SEW / LANE_W) for current vl.
// Ports    : avl, req_vsew, req_vlmul, req_rsvd  -> cfg_legal, vl_new
//            vl_cur, cur_vsew                    -> n_beats
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_vl_calc
    import vec_issue_ctrl_pkg::*;
#(
    parameter int VLEN   = 512,
    parameter int LANE_W = 128
) (
    input  logic [XLEN-1:0]  avl,
    input  logic [2:0]       req_vsew,
    input  logic [2:0]       req_vlmul,
    input  logic [XLEN-10:0] req_rsvd,   // vtype bits XLEN-2:8
    output logic             cfg_legal,
    output logic [XLEN-1:0]  vl_new,
    input  logic [XLEN-1:0]  vl_cur,
    input  logic [2:0]       cur_vsew,
    output logic [5:0]       n_beats
);

    localparam logic [XLEN-1:0] C_VLEN   = XLEN'(VLEN);
    localparam logic [XLEN-1:0] C_LANE_W = XLEN'(LANE_W);

    logic [XLEN-1:0] w_vlmax;
    logic [XLEN-1:0] w_bits;

    always_comb begin
        // VLMAX = VLEN * LMUL / SEW, with SEW = 8 << vsew
        w_vlmax   = (C_VLEN << req_vlmul) >> ({1'b0, req_vsew} + 4'd3);
        cfg_legal = vtype_fields_legal(req_vsew, req_vlmul) && (req_rsvd == '0);

        if (!cfg_legal) begin
            vl_new = '0;
        end else if (avl < w_vlmax) begin
            vl_new = avl;
        end else begin
            vl_new = w_vlmax;
        end

        // Total payload bits, rounded up to whole lanes. LANE_W is expected to
        // be a power of two so the divide reduces to a shift.
        w_bits  = vl_cur << ({1'b0, cur_vsew} + 4'd3);
        n_beats = 6'((w_bits + C_LANE_W - XLEN'(1)) / C_LANE_W);
    end

endmodule

`default_nettype wire

// File: rtl/vec_issue_ctrl.sv
// ============================================================================
// Module   : vec_issue_ctrl
// Purpose  : Vector instruction issue controller. Accepts decoded vector
//            instructions, executes vset{i}vl{i} configuration, and sequences
//            arithmetic ops into LANE_W-wide beats toward the execution unit.
// Ports    : clk, n_rst (async, active-low)
//            inst_valid/inst_ready, is_config, vec_op_valid, vec_func6,
//            vd_addr, vs1_addr, vs2_addr, avl, vtype_in        (decoder side)
//            exe_valid/exe_ready, exe_func6, exe_vd, exe_vs1, exe_vs2,
//            exe_beat, exe_last                                 (exec side)
//            vl_o, vtype_o, done, busy, illegal_inst            (status)
// Options  : VEC_ILLEGAL_TRAP_EN - when defined, a non-config op without
//            vec_op_valid pulses illegal_inst during its DONE cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_issue_ctrl
    import vec_issue_ctrl_pkg::*;
#(
    parameter int VLEN   = 512,
    parameter int LANE_W = 128
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic            is_config,
    input  logic            vec_op_valid,
    input  logic [5:0]      vec_func6,
    input  logic [4:0]      vd_addr,
    input  logic [4:0]      vs1_addr,
    input  logic [4:0]      vs2_addr,
    input  logic [XLEN-1:0] avl,
    input  logic [XLEN-1:0] vtype_in,
    output logic            exe_valid,
    input  logic            exe_ready,
    output logic [5:0]      exe_func6,
    output logic [4:0]      exe_vd,
    output logic [4:0]      exe_vs1,
    output logic [4:0]      exe_vs2,
    output logic [5:0]      exe_beat,
    output logic            exe_last,
    output logic [XLEN-1:0] vl_o,
    output logic [XLEN-1:0] vtype_o,
    output logic            done,
    output logic            busy,
    output logic            illegal_inst
);

    issue_state_e    r_state;
    issue_state_e    w_state_nxt;

    logic [5:0]      r_func6;
    logic [4:0]      r_vd;
    logic [4:0]      r_vs1;
    logic [4:0]      r_vs2;
    logic [XLEN-1:0] r_avl;
    logic [XLEN-2:0] r_vtype_req;   // requested vtype; MSB is always cleared on write
    logic [XLEN-1:0] r_vl;
    logic [XLEN-1:0] r_vtype;
    logic [5:0]      r_beat;

    logic            w_xfer;
    logic            w_cfg_legal;
    logic [XLEN-1:0] w_vl_new;
    logic [5:0]      w_n_beats;
    logic            w_last;
    logic            w_unused;

    // Requested vill bit is ignored; legality is recomputed from the fields.
    assign w_unused = vtype_in[XLEN-1];

    assign w_xfer = (r_state == ST_IDLE) && inst_valid;

    vec_vl_calc #(
        .VLEN   (VLEN),
        .LANE_W (LANE_W)
    ) u_vl_calc (
        .avl       (r_avl),
        .req_vsew  (r_vtype_req[5:3]),
        .req_vlmul (r_vtype_req[2:0]),
        .req_rsvd  (r_vtype_req[XLEN-2:8]),
        .cfg_legal (w_cfg_legal),
        .vl_new    (w_vl_new),
        .vl_cur    (r_vl),
        .cur_vsew  (r_vtype[5:3]),
        .n_beats   (w_n_beats)
    );

    assign w_last = (r_beat == (w_n_beats - 6'd1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        inst_ready  = 1'b0;
        exe_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                inst_ready = 1'b1;
                busy       = 1'b0;
                if (inst_valid) begin
                    if (is_config) begin
                        w_state_nxt = ST_CONFIG;
                    end else if (vec_op_valid && (r_vl != '0)) begin
                        // vill forces vl to zero, so this also filters vill
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_CONFIG: begin
                w_state_nxt = ST_DONE;
            end
            ST_EXEC: begin
                exe_valid = 1'b1;
                if (exe_ready && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction capture, architectural vl/vtype, beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_func6     <= '0;
            r_vd        <= '0;
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_avl       <= '0;
            r_vtype_req <= '0;
            r_vl        <= '0;
            r_vtype     <= C_VTYPE_VILL;
            r_beat      <= '0;
        end else begin
            if (w_xfer) begin
                r_func6     <= vec_func6;
                r_vd        <= vd_addr;
                r_vs1       <= vs1_addr;
                r_vs2       <= vs2_addr;
                r_avl       <= avl;
                r_vtype_req <= vtype_in[XLEN-2:0];
                r_beat      <= '0;
            end

            if (r_state == ST_CONFIG) begin
                r_vl    <= w_vl_new;
                r_vtype <= w_cfg_legal ? {1'b0, r_vtype_req} : C_VTYPE_VILL;
            end

            // Counter parks on the last beat; it is cleared by the next transfer.
            if ((r_state == ST_EXEC) && exe_ready && !w_last) begin
                r_beat <= r_beat + 6'd1;
            end
        end
    end

    assign exe_func6 = r_func6;
    assign exe_vd    = r_vd;
    assign exe_vs1   = r_vs1;
    assign exe_vs2   = r_vs2;
    assign exe_beat  = r_beat;
    assign exe_last  = exe_valid && w_last;
    assign vl_o      = r_vl;
    assign vtype_o   = r_vtype;

`ifdef VEC_ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_trap <= 1'b0;
        end else if (w_xfer) begin
            r_trap <= !is_config && !vec_op_valid;
        end
    end

    assign illegal_inst = (r_state == ST_DONE) && r_trap;
`else
    assign illegal_inst = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_issue_ctrl.sv
// ============================================================================
// Module   : tb_vec_issue_ctrl
// Purpose  : Self-checking bench for vec_issue_ctrl. Directed instructions
//            push hand-computed beats/completions into a scoreboard queue; a
//            monitor pops and compares whenever a beat handshakes or done
//            pulses.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vec_issue_ctrl;
    import vec_issue_ctrl_pkg::*;

    localparam int VLEN   = 512;
    localparam int LANE_W = 128;
`ifdef VEC_ILLEGAL_TRAP_EN
    localparam bit C_TRAP = 1'b1;
`else
    localparam bit C_TRAP = 1'b0;
`endif

    logic            clk;
    logic            n_rst;
    logic            inst_valid;
    logic            inst_ready;
    logic            is_config;
    logic            vec_op_valid;
    logic [5:0]      vec_func6;
    logic [4:0]      vd_addr;
    logic [4:0]      vs1_addr;
    logic [4:0]      vs2_addr;
    logic [XLEN-1:0] avl;
    logic [XLEN-1:0] vtype_in;
    logic            exe_valid;
    logic            exe_ready;
    logic [5:0]      exe_func6;
    logic [4:0]      exe_vd;
    logic [4:0]      exe_vs1;
    logic [4:0]      exe_vs2;
    logic [5:0]      exe_beat;
    logic            exe_last;
    logic [XLEN-1:0] vl_o;
    logic [XLEN-1:0] vtype_o;
    logic            done;
    logic            busy;
    logic            illegal_inst;

    vec_issue_ctrl #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .is_config    (is_config),
        .vec_op_valid (vec_op_valid),
        .vec_func6    (vec_func6),
        .vd_addr      (vd_addr),
        .vs1_addr     (vs1_addr),
        .vs2_addr     (vs2_addr),
        .avl          (avl),
        .vtype_in     (vtype_in),
        .exe_valid    (exe_valid),
        .exe_ready    (exe_ready),
        .exe_func6    (exe_func6),
        .exe_vd       (exe_vd),
        .exe_vs1      (exe_vs1),
        .exe_vs2      (exe_vs2),
        .exe_beat     (exe_beat),
        .exe_last     (exe_last),
        .vl_o         (vl_o),
        .vtype_o      (vtype_o),
        .done         (done),
        .busy         (busy),
        .illegal_inst (illegal_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [5:0] func6;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [5:0] beat;
        bit         last;
        bit         ill;
        logic [31:0] vl;
        logic [31:0] vtype;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    // ------------------------------------------------------------------
    // Monitor: sample mid-cycle, pop one expectation per event
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (n_rst) begin
            if (exe_valid && exe_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("beat_unexpected: got beat %0d expected none", exe_beat));
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        fail_now($sformatf("beat_order: got beat %0d expected done", exe_beat));
                    end else begin
                        chk("beat_idx",   exe_beat,  e.beat);
                        chk("beat_last",  exe_last,  e.last);
                        chk("beat_func6", exe_func6, e.func6);
                        chk("beat_vd",    exe_vd,    e.vd);
                        chk("beat_vs1",   exe_vs1,   e.vs1);
                        chk("beat_vs2",   exe_vs2,   e.vs2);
                    end
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    fail_now("done_unexpected: got done expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done) begin
                        fail_now($sformatf("done_order: got done expected beat %0d", e.beat));
                    end else begin
                        chk("done_illegal", illegal_inst, e.ill);
                        chk("done_vl",      vl_o,         e.vl);
                        chk("done_vtype",   vtype_o,      e.vtype);
                    end
                end
            end
            if (illegal_inst && !done) begin
                fail_now("illegal_outside_done: got 1 expected 0");
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue one instruction and follow it to completion.
    // exp_lat: cycle (transfer cycle = 0) in which done must appear, 0 = skip
    // stall_at: beat held with exe_ready low for 2 cycles, -1 = none
    // abort_at: beat at which reset is asserted, -1 = none
    // ------------------------------------------------------------------
    task automatic issue(input bit cfg, input bit opv, input logic [5:0] f6,
                         input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [31:0] avl_v, input logic [31:0] vt_v,
                         input int nbeats, input logic [31:0] ev_vl, input logic [31:0] ev_vtype,
                         input bit ev_ill, input int exp_lat, input int stall_at, input int abort_at);
        exp_t e;
        int   cyc;
        int   stall_cnt;
        bit   stalled_prev;

        for (int b = 0; b < nbeats; b++) begin
            e = '{is_done: 1'b0, func6: f6, vd: vd, vs1: vs1, vs2: vs2,
                  beat: 6'(b), last: (b == nbeats - 1), ill: 1'b0, vl: '0, vtype: '0};
            exp_q.push_back(e);
        end
        e = '{is_done: 1'b1, func6: '0, vd: '0, vs1: '0, vs2: '0,
              beat: '0, last: 1'b0, ill: ev_ill, vl: ev_vl, vtype: ev_vtype};
        exp_q.push_back(e);

        exe_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 20 && !inst_ready; k++) begin
            @(posedge clk); #1;
        end
        chk("inst_ready_idle", inst_ready, 1'b1);

        inst_valid   = 1'b1;
        is_config    = cfg;
        vec_op_valid = opv;
        vec_func6    = f6;
        vd_addr      = vd;
        vs1_addr     = vs1;
        vs2_addr     = vs2;
        avl          = avl_v;
        vtype_in     = vt_v;
        @(posedge clk); #1;
        // Scramble fields after the transfer; the DUT must use captured copies
        inst_valid   = 1'b0;
        is_config    = ~cfg;
        vec_op_valid = ~opv;
        vec_func6    = ~f6;
        vd_addr      = ~vd;
        vs1_addr     = ~vs1;
        vs2_addr     = ~vs2;
        avl          = 32'hDEAD_BEEF;
        vtype_in     = 32'h0000_0003;

        cyc          = 1;
        stall_cnt    = 0;
        stalled_prev = 1'b0;
        while (cyc < 200) begin
            if (stalled_prev) begin
                chk("stall_hold_beat",  exe_beat,  6'(stall_at));
                chk("stall_hold_valid", exe_valid, 1'b1);
                chk("stall_hold_vd",    exe_vd,    vd);
            end
            if (abort_at >= 0 && exe_valid && exe_beat == 6'(abort_at)) begin
                n_rst = 1'b0;
                #1;
                chk("abort_exe_valid",  exe_valid,  1'b0);
                chk("abort_busy",       busy,       1'b0);
                chk("abort_inst_ready", inst_ready, 1'b1);
                exp_q.delete();
                exe_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                n_rst = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("post_abort_exe_valid", exe_valid, 1'b0);
                end
                chk("post_abort_vl",         vl_o,       32'h0);
                chk("post_abort_vtype",      vtype_o,    32'h8000_0000);
                chk("post_abort_inst_ready", inst_ready, 1'b1);
                return;
            end
            if (done) break;
            if (stall_at >= 0 && exe_valid && exe_beat == 6'(stall_at) && stall_cnt < 2) begin
                exe_ready    = 1'b0;
                stall_cnt++;
                stalled_prev = 1'b1;
            end else begin
                exe_ready    = 1'b1;
                stalled_prev = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end

        if (!done) begin
            fail_now($sformatf("done_timeout: got no done after %0d cycles expected done", cyc));
        end else if (exp_lat > 0) begin
            chk("done_latency", cyc, exp_lat);
        end
        exe_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        n_rst        = 1'b0;
        inst_valid   = 1'b0;
        is_config    = 1'b0;
        vec_op_valid = 1'b0;
        vec_func6    = '0;
        vd_addr      = '0;
        vs1_addr     = '0;
        vs2_addr     = '0;
        avl          = '0;
        vtype_in     = '0;
        exe_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vl",         vl_o,         32'h0);
        chk("rst_vtype",      vtype_o,      32'h8000_0000);
        chk("rst_inst_ready", inst_ready,   1'b1);
        chk("rst_exe_valid",  exe_valid,    1'b0);
        chk("rst_busy",       busy,         1'b0);
        chk("rst_done",       done,         1'b0);
        chk("rst_illegal",    illegal_inst, 1'b0);
        n_rst = 1'b1;

        // cfg  opv  f6     vd  vs1 vs2 avl    vtype         beats vl   vtype         ill     lat stall abort
        issue(1, 0, 6'h00, 0, 0, 0, 100,  32'h0000_0010, 0,  16,  32'h0000_0010, 0,      2,  -1, -1);
        issue(0, 1, 6'h00, 4, 1, 2, 0,    0,             4,  16,  32'h0000_0010, 0,      7,   1, -1);
        // SEW64 is unsupported -> vill, then an op completes with no beats
        issue(1, 0, 6'h00, 0, 0, 0, 100,  32'h0000_0018, 0,  0,   32'h8000_0000, 0,      2,  -1, -1);
        issue(0, 1, 6'h05, 3, 3, 3, 0,    0,             0,  0,   32'h8000_0000, 0,      1,  -1, -1);
        // Requested vill bit is ignored and cleared
        issue(1, 0, 6'h00, 0, 0, 0, 100,  32'h8000_0010, 0,  16,  32'h0000_0010, 0,      2,  -1, -1);
        issue(0, 0, 6'h3F, 5, 6, 7, 0,    0,             0,  16,  32'h0000_0010, C_TRAP, 1,  -1, -1);
        // SEW16 LMUL1: VLMAX 32, vl 5 -> 80 bits -> single beat
        issue(1, 0, 6'h00, 0, 0, 0, 5,    32'h0000_0008, 0,  5,   32'h0000_0008, 0,      2,  -1, -1);
        issue(0, 1, 6'h01, 7, 8, 9, 0,    0,             1,  5,   32'h0000_0008, 0,      2,  -1, -1);
        // SEW8 LMUL8 with vta/vma: VLMAX 512, 4096 bits -> 32 beats
        issue(1, 0, 6'h00, 0, 0, 0, 5000, 32'h0000_00C3, 0,  512, 32'h0000_00C3, 0,      2,  -1, -1);
        issue(0, 1, 6'h2A, 31, 0, 17, 0,  0,             32, 512, 32'h0000_00C3, 0,      33, -1, -1);
        // Reserved vtype bit 8 and reserved LMUL 100 are illegal
        issue(1, 0, 6'h00, 0, 0, 0, 100,  32'h0000_0100, 0,  0,   32'h8000_0000, 0,      2,  -1, -1);
        issue(1, 0, 6'h00, 0, 0, 0, 100,  32'h0000_0004, 0,  0,   32'h8000_0000, 0,      2,  -1, -1);
        // Legal vtype with avl 0 -> vl 0, op completes with no beats
        issue(1, 0, 6'h00, 0, 0, 0, 0,    32'h0000_0010, 0,  0,   32'h0000_0010, 0,      2,  -1, -1);
        issue(0, 1, 6'h02, 1, 1, 1, 0,    0,             0,  0,   32'h0000_0010, 0,      1,  -1, -1);
        // Reset mid-EXEC at beat 2
        issue(1, 0, 6'h00, 0, 0, 0, 100,  32'h0000_0010, 0,  16,  32'h0000_0010, 0,      2,  -1, -1);
        issue(0, 1, 6'h00, 4, 1, 2, 0,    0,             4,  16,  32'h0000_0010, 0,      0,  -1,  2);
        // Recovery: SEW32 LMUL2, VLMAX 32, vl 7 -> 224 bits -> 2 beats
        issue(1, 0, 6'h00, 0, 0, 0, 7,    32'h0000_0011, 0,  7,   32'h0000_0011, 0,      2,  -1, -1);
        issue(0, 1, 6'h10, 9, 10, 11, 0,  0,             2,  7,   32'h0000_0011, 0,      3,  -1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
